// File: rtl/bp_me_stream_to_wormhole_packetizer.sv
// Injection-side packetizer: BedRock stream (header + data beats) to
// wormhole flits. Header flits come from a capture register; data is passed straight through.
module bp_me_stream_to_wormhole_packetizer #(
  parameter int          paddr_width_p      = 40,
  parameter int          flit_width_p       = 64,
  parameter int          cord_width_p       = 8,
  parameter int          len_width_p        = 5,
  parameter int          cid_width_p        = 0,
  parameter int          pr_payload_width_p = 32,
  parameter int          pr_hdr_width_p     =
    pr_payload_width_p + 3 + paddr_width_p + 8,
  parameter logic [15:0] pr_stream_mask_p   = 16'h00AA,
  parameter int          pr_data_width_p    = flit_width_p,
  parameter int          wh_hdr_width_p     =
    cord_width_p + len_width_p + cid_width_p + pr_hdr_width_p,
  localparam int         cid_lp             =
    (cid_width_p > 0) ? cid_width_p : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [pr_hdr_width_p-1:0]  pr_hdr_i,
  input  logic [pr_data_width_p-1:0] pr_data_i,
  input  logic                       pr_v_i,
  output logic                       pr_ready_and_o,
  input  logic [cord_width_p-1:0]    dst_cord_i,
  input  logic [cid_lp-1:0]          dst_cid_i,
  output logic [flit_width_p-1:0]    link_data_o,
  output logic                       link_v_o,
  input  logic                       link_ready_and_i
);

  localparam int hdr_len_lp =
    (wh_hdr_width_p + flit_width_p - 1) / flit_width_p;
  localparam int hcnt_w_lp     = $clog2(hdr_len_lp + 1);
  localparam int pack_w_lp     = hdr_len_lp * flit_width_p;
  localparam int size_lsb_lp   = 8 + paddr_width_p;
  localparam int flit_shift_lp = $clog2(flit_width_p);
  localparam int cid_off_lp    = cord_width_p + len_width_p;
  localparam int prh_off_lp    = cid_off_lp + cid_width_p;
  localparam logic [hcnt_w_lp-1:0] hdr_last_lp =
    hcnt_w_lp'(hdr_len_lp - 1);

  if (pr_data_width_p != flit_width_p) begin : g_bad_data_w
    $error("pr_data_width_p must equal flit_width_p");
  end
  if (pr_hdr_width_p != pr_payload_width_p + 3 + paddr_width_p + 8)
  begin : g_bad_hdr_w
    $error("pr_hdr_width_p does not match header layout");
  end

  typedef enum logic [1:0] {
    e_ready,
    e_hdr,
    e_data
  } state_e;

  state_e                 state_q, state_d;
  logic [pack_w_lp-1:0]   hdr_q, hdr_d;
  logic [len_width_p-1:0] beats_q, beats_d;
  logic                   has_data_q, has_data_d;
  logic [hcnt_w_lp-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [len_width_p-1:0] data_cnt_q, data_cnt_d;

  logic [3:0]             msg_type;
  logic [2:0]             msg_size;
  logic                   msg_has_data;
  int                     beats_int;
  logic [len_width_p-1:0] msg_beats;
  logic [len_width_p-1:0] msg_len;
  logic [pack_w_lp-1:0]   packed_hdr;

  always_comb begin
    msg_type     = pr_hdr_i[3:0];
    msg_size     = pr_hdr_i[size_lsb_lp +: 3];
    msg_has_data = pr_stream_mask_p[msg_type];
    beats_int    = (32'd8 << msg_size) >> flit_shift_lp;
    if (beats_int == 0) beats_int = 1;
    if (!msg_has_data) beats_int = 0;
    msg_beats = len_width_p'(beats_int);
    msg_len   = len_width_p'(hdr_len_lp + beats_int - 1);
    // With no cid field the header overwrites the unused cid bit.
    packed_hdr = '0;
    packed_hdr[0 +: cord_width_p]         = dst_cord_i;
    packed_hdr[cord_width_p +: len_width_p] = msg_len;
    packed_hdr[cid_off_lp +: cid_lp]      = dst_cid_i;
    packed_hdr[prh_off_lp +: pr_hdr_width_p] = pr_hdr_i;
  end

  always_comb begin
    state_d        = state_q;
    hdr_d          = hdr_q;
    beats_d        = beats_q;
    has_data_d     = has_data_q;
    hdr_cnt_d      = hdr_cnt_q;
    data_cnt_d     = data_cnt_q;
    link_v_o       = 1'b0;
    link_data_o    = '0;
    pr_ready_and_o = 1'b0;
    unique case (state_q)
      e_ready: begin
        if (pr_v_i) begin
          hdr_d      = packed_hdr;
          beats_d    = msg_beats;
          has_data_d = msg_has_data;
          hdr_cnt_d  = '0;
          state_d    = e_hdr;
        end
      end
      e_hdr: begin
        link_v_o    = 1'b1;
        link_data_o = hdr_q[flit_width_p-1:0];
        if (link_ready_and_i) begin
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          hdr_d     = hdr_q >> flit_width_p;
          if (hdr_cnt_q == hdr_last_lp) begin
            if (has_data_q) begin
              data_cnt_d = '0;
              state_d    = e_data;
            end else begin
              // Header-only message: its single beat retires here.
              pr_ready_and_o = 1'b1;
              state_d        = e_ready;
            end
          end
        end
      end
      e_data: begin
        link_v_o       = pr_v_i;
        link_data_o    = pr_data_i;
        pr_ready_and_o = link_ready_and_i;
        if (pr_v_i && link_ready_and_i) begin
          data_cnt_d = data_cnt_q + 1'b1;
          if (data_cnt_q == beats_q - 1'b1) state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_ready;
      hdr_q      <= '0;
      beats_q    <= '0;
      has_data_q <= 1'b0;
      hdr_cnt_q  <= '0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      beats_q    <= beats_d;
      has_data_q <= has_data_d;
      hdr_cnt_q  <= hdr_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

endmodule

// File: tb/tb_bp_me_stream_to_wormhole_packetizer.sv
// Random-stream bench: expected flits go to a queue when a message is
// issued; a monitor pops and compares on every link handshake.
module tb_bp_me_stream_to_wormhole_packetizer;

  localparam int FW   = 64;
  localparam int CW   = 8;
  localparam int LW   = 5;
  localparam int CIDW = 2;
  localparam int PA   = 40;
  localparam int PL   = 32;
  localparam int HW   = PL + 3 + PA + 8;
  localparam logic [15:0] MASK = 16'h00AA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [HW-1:0] pr_hdr = '0;
  logic [FW-1:0] pr_data = '0;
  logic          pr_v = 1'b0;
  logic          pr_ready;
  logic [CW-1:0] cord = '0;
  logic [CIDW-1:0] cid = '0;
  logic [FW-1:0] link_data;
  logic          link_v;
  logic          link_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit rdy_random = 1'b0;
  bit dead = 1'b0;
  logic [FW-1:0] exp_q[$];
  logic [15:0]   mask_v = MASK;

  always #5 clk = ~clk;

  bp_me_stream_to_wormhole_packetizer #(
    .paddr_width_p(PA), .flit_width_p(FW),
    .cord_width_p(CW), .len_width_p(LW),
    .cid_width_p(CIDW), .pr_payload_width_p(PL),
    .pr_hdr_width_p(HW), .pr_stream_mask_p(MASK),
    .pr_data_width_p(FW)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .pr_hdr_i(pr_hdr), .pr_data_i(pr_data),
    .pr_v_i(pr_v), .pr_ready_and_o(pr_ready),
    .dst_cord_i(cord), .dst_cid_i(cid),
    .link_data_o(link_data), .link_v_o(link_v),
    .link_ready_and_i(link_ready)
  );

  task automatic check(input string nm,
                       input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int model_beats(logic [3:0] t, logic [2:0] sz);
    int bits;
    bits = 8 * (1 << sz);
    if (!mask_v[t]) return 0;
    if (bits < FW) return 1;
    return bits / FW;
  endfunction

  task automatic wait_hs(output bit ok);
    bit hs;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      hs = pr_v && pr_ready;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL stream_handshake: timed out, pr_ready never 1");
    dead = 1'b1;
  endtask

  task automatic send_msg(input logic [3:0] t, input logic [2:0] sz,
                          input logic [CW-1:0] dc, input int abort_at);
    logic [HW-1:0]  h;
    logic [127:0]   w;
    logic [LW-1:0]  len;
    logic [CIDW-1:0] dcid;
    logic [FW-1:0]  d[$];
    int nb, nconsume;
    bit ok;
    h = {$urandom(), sz, 40'({$urandom(), $urandom()}),
         4'($urandom_range(15)), t};
    dcid = CIDW'($urandom_range(3));
    nb = model_beats(t, sz);
    len = LW'(2 + nb - 1);
    w = '0;
    w[97:0] = {h, dcid, len, dc};
    exp_q.push_back(w[63:0]);
    exp_q.push_back(w[127:64]);
    for (int b = 0; b < nb; b++) begin
      d.push_back({$urandom(), $urandom()});
      exp_q.push_back(d[b]);
    end
    nconsume = (nb == 0) ? 1 : nb;
    pr_hdr = h;
    cord = dc;
    cid = dcid;
    for (int b = 0; b < nconsume; b++) begin
      pr_data = (nb > 0) ? d[b] : {$urandom(), $urandom()};
      pr_v = 1'b1;
      wait_hs(ok);
      if (!ok) return;
      if (abort_at == b + 1) begin
        rst = 1'b1;
        pr_v = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_link_v", FW'(link_v), FW'(0));
        check("abort_pr_ready", FW'(pr_ready), FW'(0));
        @(posedge clk); #1;
        return;
      end
      if (b + 1 < nconsume && $urandom_range(3) == 0) begin
        pr_v = 1'b0;
        @(posedge clk); #1;
      end
    end
    pr_v = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      link_ready = rdy_random ? 1'($urandom_range(1)) : 1'b1;
      if (rst) link_ready = 1'b0;
    end
  end

  initial begin
    bit stalled;
    logic [FW-1:0] held;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (!link_ready) check("ready_leak", FW'(pr_ready), FW'(0));
        if (stalled) begin
          check("hold_v", FW'(link_v), FW'(1));
          check("hold_data", link_data, held);
        end
        if (link_v && link_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL extra_flit: got %h expected none", link_data);
          end else begin
            check("flit", link_data, exp_q.pop_front());
          end
        end
        stalled = link_v && !link_ready;
        held = link_data;
      end
    end
  end

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_link_v", FW'(link_v), FW'(0));
    check("rst_pr_ready", FW'(pr_ready), FW'(0));
    check("rst_link_data", link_data, FW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_link_v", FW'(link_v), FW'(0));
    check("post_rst_pr_ready", FW'(pr_ready), FW'(0));
    @(posedge clk); #1;

    send_msg(4'd0, 3'd3, 8'h05, 0);
    if (!dead) send_msg(4'd1, 3'd6, 8'h12, 0);
    if (!dead) send_msg(4'd1, 3'd2, 8'h34, 0);
    rdy_random = 1'b1;
    for (int i = 0; i < 20 && !dead; i++)
      send_msg(4'd3, 3'd6, 8'($urandom_range(255)), 0);
    if (!dead) send_msg(4'd1, 3'd6, 8'h77, 3);
    if (!dead) send_msg(4'd2, 3'd3, 8'h05, 0);
    for (int i = 0; i < 1000 && !dead; i++)
      send_msg(4'($urandom_range(15)), 3'($urandom_range(7)),
               8'($urandom_range(255)), 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d flits outstanding, expected 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
